// File: rtl/riscv_v_mask_rf_arb.sv
`default_nettype none
// riscv_v_mask_rf_arb: per-port round-robin sharing of the mask RF read/write ports,
// read-response valid generation for the RF read latency and same-cycle write bypass.

module riscv_v_mask_rf_rr #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] win;
    logic          found;
    int            cand;

    // First requester at or above the pointer, wrapping past N-1.
    always_comb begin
        gnt_o = '0;
        win   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) cand = cand - N;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                win         = IW'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) ptr_d = (win == IW'(N - 1)) ? '0 : win + IW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

module riscv_v_mask_rf_arb #(
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 128,
    parameter bit RD_ASYNC = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD-1:0]          rd_req_valid_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_req_addr_i,
    output logic [NUM_RD-1:0]          rd_req_ready_o,
    output logic [NUM_RD-1:0]          rd_rsp_valid_o,
    output logic [DATA_W-1:0]          rd_rsp_data_o,
    input  logic [NUM_WR-1:0]          wr_req_valid_i,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_req_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]   wr_req_data_i,
    output logic [NUM_WR-1:0]          wr_req_ready_o,
    output logic [ADDR_W-1:0]          rf_rd_addr_o,
    input  logic [DATA_W-1:0]          rf_rd_data_i,
    output logic                       rf_wr_en_o,
    output logic [ADDR_W-1:0]          rf_wr_addr_o,
    output logic [DATA_W-1:0]          rf_wr_data_o
);
    localparam int RD_IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int WR_IW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [NUM_RD-1:0] rd_gnt;
    logic [NUM_WR-1:0] wr_gnt;
    logic              hit;

    riscv_v_mask_rf_rr #(.N(NUM_RD), .IW(RD_IW)) u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (rd_req_valid_i),
        .gnt_o (rd_gnt)
    );

    riscv_v_mask_rf_rr #(.N(NUM_WR), .IW(WR_IW)) u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (wr_req_valid_i),
        .gnt_o (wr_gnt)
    );

    assign rd_req_ready_o = rd_gnt;
    assign wr_req_ready_o = wr_gnt;
    assign rf_wr_en_o     = |wr_gnt;

    // One-hot AND-OR muxes: zero fields when nobody is granted.
    always_comb begin
        rf_rd_addr_o = '0;
        for (int i = 0; i < NUM_RD; i++)
            if (rd_gnt[i]) rf_rd_addr_o = rd_req_addr_i[i*ADDR_W +: ADDR_W];
    end

    always_comb begin
        rf_wr_addr_o = '0;
        rf_wr_data_o = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_gnt[i]) begin
                rf_wr_addr_o = wr_req_addr_i[i*ADDR_W +: ADDR_W];
                rf_wr_data_o = wr_req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign hit = BYPASS && (|rd_gnt) && (|wr_gnt) && (rf_rd_addr_o == rf_wr_addr_o);

    if (RD_ASYNC) begin : g_rsp_async
        assign rd_rsp_valid_o = rd_gnt;
        assign rd_rsp_data_o  = hit ? rf_wr_data_o : rf_rd_data_i;
    end else begin : g_rsp_sync
        logic [NUM_RD-1:0] rsp_valid_q;
        logic              hit_q;
        logic [DATA_W-1:0] byp_data_q;

        // The RF returns pre-write data one cycle later, so the bypass decision travels with it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rsp_valid_q <= '0;
                hit_q       <= 1'b0;
                byp_data_q  <= '0;
            end else begin
                rsp_valid_q <= rd_gnt;
                hit_q       <= hit;
                byp_data_q  <= rf_wr_data_o;
            end
        end

        assign rd_rsp_valid_o = rsp_valid_q;
        assign rd_rsp_data_o  = hit_q ? byp_data_q : rf_rd_data_i;
    end
endmodule
`default_nettype wire

// File: tb/tb_riscv_v_mask_rf_arb.sv
`default_nettype none
// Bench: three arbiter configurations (async+bypass, sync no-bypass, sync+bypass) with RF models,
// checked against a transaction-level reference model.
module tb_riscv_v_mask_rf_arb;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0] rd_v = '0;
    logic [AW-1:0] rd_a [NR] = '{default: '0};
    logic [NW-1:0] wr_v = '0;
    logic [AW-1:0] wr_a [NW] = '{default: '0};
    logic [DW-1:0] wr_d [NW] = '{default: '0};
    logic [NR*AW-1:0] rd_a_flat;
    logic [NW*AW-1:0] wr_a_flat;
    logic [NW*DW-1:0] wr_d_flat;
    assign rd_a_flat = {rd_a[1], rd_a[0]};
    assign wr_a_flat = {wr_a[1], wr_a[0]};
    assign wr_d_flat = {wr_d[1], wr_d[0]};

    // DUT outputs: a = async/bypass, s = sync/no bypass, b = sync/bypass
    logic [NR-1:0] a_rr, a_rv, s_rr, s_rv, b_rr, b_rv;
    logic [NW-1:0] a_wr, s_wr, b_wr;
    logic [DW-1:0] a_rd, s_rd, b_rd, a_wd, s_wd, b_wd, a_rfd, s_rfd, b_rfd;
    logic [AW-1:0] a_ra, s_ra, b_ra, a_wa, s_wa, b_wa;
    logic          a_we, s_we, b_we;

    riscv_v_mask_rf_arb #(.NUM_RD(NR), .NUM_WR(NW), .ADDR_W(AW), .DATA_W(DW),
                          .RD_ASYNC(1'b1), .BYPASS(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid_i(rd_v), .rd_req_addr_i(rd_a_flat), .rd_req_ready_o(a_rr),
        .rd_rsp_valid_o(a_rv), .rd_rsp_data_o(a_rd),
        .wr_req_valid_i(wr_v), .wr_req_addr_i(wr_a_flat), .wr_req_data_i(wr_d_flat),
        .wr_req_ready_o(a_wr), .rf_rd_addr_o(a_ra), .rf_rd_data_i(a_rfd),
        .rf_wr_en_o(a_we), .rf_wr_addr_o(a_wa), .rf_wr_data_o(a_wd));

    riscv_v_mask_rf_arb #(.NUM_RD(NR), .NUM_WR(NW), .ADDR_W(AW), .DATA_W(DW),
                          .RD_ASYNC(1'b0), .BYPASS(1'b0)) u_dut_s (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid_i(rd_v), .rd_req_addr_i(rd_a_flat), .rd_req_ready_o(s_rr),
        .rd_rsp_valid_o(s_rv), .rd_rsp_data_o(s_rd),
        .wr_req_valid_i(wr_v), .wr_req_addr_i(wr_a_flat), .wr_req_data_i(wr_d_flat),
        .wr_req_ready_o(s_wr), .rf_rd_addr_o(s_ra), .rf_rd_data_i(s_rfd),
        .rf_wr_en_o(s_we), .rf_wr_addr_o(s_wa), .rf_wr_data_o(s_wd));

    riscv_v_mask_rf_arb #(.NUM_RD(NR), .NUM_WR(NW), .ADDR_W(AW), .DATA_W(DW),
                          .RD_ASYNC(1'b0), .BYPASS(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid_i(rd_v), .rd_req_addr_i(rd_a_flat), .rd_req_ready_o(b_rr),
        .rd_rsp_valid_o(b_rv), .rd_rsp_data_o(b_rd),
        .wr_req_valid_i(wr_v), .wr_req_addr_i(wr_a_flat), .wr_req_data_i(wr_d_flat),
        .wr_req_ready_o(b_wr), .rf_rd_addr_o(b_ra), .rf_rd_data_i(b_rfd),
        .rf_wr_en_o(b_we), .rf_wr_addr_o(b_wa), .rf_wr_data_o(b_wd));

    // Register-file models: async read for a, one-cycle registered read for s and b.
    logic [DW-1:0] mem_a [32] = '{default: '0};
    logic [DW-1:0] mem_s [32] = '{default: '0};
    logic [DW-1:0] mem_b [32] = '{default: '0};
    logic [DW-1:0] rdq_s = '0;
    logic [DW-1:0] rdq_b = '0;
    assign a_rfd = mem_a[a_ra];
    assign s_rfd = rdq_s;
    assign b_rfd = rdq_b;
    always @(posedge clk) begin
        if (a_we) mem_a[a_wa] <= a_wd;
        if (s_we) mem_s[s_wa] <= s_wd;
        if (b_we) mem_b[b_wa] <= b_wd;
        rdq_s <= mem_s[s_ra];
        rdq_b <= mem_b[b_ra];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int            rd_ptr = 0, wr_ptr = 0;
    logic [DW-1:0] exp_mem [32] = '{default: '0};
    int            pend_rw = -1;
    logic [DW-1:0] pend_old = '0, pend_byp = '0;
    int            cur_rw, cur_ww, last_rw = -1, last_ww = -1;
    logic [DW-1:0] cur_old, cur_byp;
    logic [NR-1:0] e_rr;
    logic [NW-1:0] e_wr;
    logic [AW-1:0] e_ra, e_wa;
    logic [DW-1:0] e_wd;

    function automatic int pick(input logic [1:0] v, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (ptr + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_dut(input string n, input logic [NR-1:0] rr, input logic [NR-1:0] rv,
                             input logic [DW-1:0] rd, input logic [AW-1:0] ra, input logic [NW-1:0] wr,
                             input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic [NR-1:0] x_rv, input bit chk_d, input logic [DW-1:0] x_d);
        check({n, ".rd_ready"}, rr, e_rr);
        check({n, ".rf_rd_addr"}, ra, e_ra);
        check({n, ".wr_ready"}, wr, e_wr);
        check({n, ".rf_wr_en"}, we, |e_wr);
        check({n, ".rf_wr_addr"}, wa, e_wa);
        check({n, ".rf_wr_data"}, wd, e_wd);
        check({n, ".rsp_valid"}, rv, x_rv);
        if (chk_d) check({n, ".rsp_data"}, rd, x_d);
    endtask

    task automatic check_cycle();
        @(negedge clk);
        cur_rw  = pick(rd_v, rd_ptr, NR);
        cur_ww  = pick(wr_v, wr_ptr, NW);
        e_rr    = (cur_rw >= 0) ? NR'(1 << cur_rw) : '0;
        e_wr    = (cur_ww >= 0) ? NW'(1 << cur_ww) : '0;
        e_ra    = (cur_rw >= 0) ? rd_a[cur_rw] : '0;
        e_wa    = (cur_ww >= 0) ? wr_a[cur_ww] : '0;
        e_wd    = (cur_ww >= 0) ? wr_d[cur_ww] : '0;
        cur_old = (cur_rw >= 0) ? exp_mem[rd_a[cur_rw]] : '0;
        cur_byp = (cur_rw >= 0 && cur_ww >= 0 && rd_a[cur_rw] == wr_a[cur_ww]) ? wr_d[cur_ww] : cur_old;
        check_dut("a", a_rr, a_rv, a_rd, a_ra, a_wr, a_we, a_wa, a_wd, e_rr, cur_rw >= 0, cur_byp);
        check_dut("s", s_rr, s_rv, s_rd, s_ra, s_wr, s_we, s_wa, s_wd,
                  (pend_rw >= 0) ? NR'(1 << pend_rw) : '0, pend_rw >= 0, pend_old);
        check_dut("b", b_rr, b_rv, b_rd, b_ra, b_wr, b_we, b_wa, b_wd,
                  (pend_rw >= 0) ? NR'(1 << pend_rw) : '0, pend_rw >= 0, pend_byp);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) begin
            pend_rw  = cur_rw;
            pend_old = cur_old;
            pend_byp = cur_byp;
            if (cur_ww >= 0) exp_mem[wr_a[cur_ww]] = wr_d[cur_ww];
            if (cur_rw >= 0) rd_ptr = (cur_rw + 1) % NR;
            if (cur_ww >= 0) wr_ptr = (cur_ww + 1) % NW;
            last_rw = cur_rw;
            last_ww = cur_ww;
        end
        #1;
    endtask

    task automatic step();
        check_cycle();
        advance();
    endtask

    initial begin
        // Reset state: nothing granted, nothing valid
        repeat (2) step();
        rst_n = 1'b1;

        // Both requesters on each port: grants alternate starting with requester 0
        rd_v = 2'b11; rd_a[0] = 5'd1; rd_a[1] = 5'd2;
        wr_v = 2'b11; wr_a[0] = 5'd1; wr_a[1] = 5'd2; wr_d[0] = 16'h0011; wr_d[1] = 16'h0022;
        for (int k = 0; k < 4; k++) begin
            check_cycle();
            check("alt.wr_ready", a_wr, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("alt.rd_ready", a_rr, (k % 2 == 0) ? 2'b01 : 2'b10);
            advance();
        end
        rd_v = '0; wr_v = '0;

        // Write 0xA5 to register 3, then read it back through requester 1
        wr_v = 2'b01; wr_a[0] = 5'd3; wr_d[0] = 16'h00A5;
        check_cycle();
        check("t1.wr_en", a_we, 1'b1);
        check("t1.wr_data", a_wd, 16'h00A5);
        advance();
        wr_v = '0; rd_v = 2'b10; rd_a[1] = 5'd3;
        check_cycle();
        check("t1.a_rsp", {a_rv, a_rd}, {2'b10, 16'h00A5});
        check("t1.s_rsp_early", s_rv, 2'b00);
        advance();
        rd_v = '0;
        check_cycle();
        check("t1.s_rsp", {s_rv, s_rd}, {2'b10, 16'h00A5});
        advance();

        // Same-cycle read/write of register 5 (old value 0)
        wr_v = 2'b10; wr_a[1] = 5'd5; wr_d[1] = 16'h003C;
        rd_v = 2'b01; rd_a[0] = 5'd5;
        check_cycle();
        check("byp.a_data", a_rd, 16'h003C);
        advance();
        wr_v = '0; rd_v = '0;
        check_cycle();
        check("byp.s_data", s_rd, 16'h0000);
        check("byp.b_data", b_rd, 16'h003C);
        advance();

        // Only requester 1 active on each port
        rd_v = 2'b10; wr_v = 2'b10; wr_d[1] = 16'h0077;
        for (int k = 0; k < 3; k++) begin
            check_cycle();
            check("only1.rd_ready", a_rr, 2'b10);
            check("only1.wr_ready", a_wr, 2'b10);
            advance();
        end
        rd_v = '0; wr_v = '0;
        step();

        // Reset between a sync grant and its response; pointers were left at 1
        rd_v = 2'b01; rd_a[0] = 5'd3; wr_v = 2'b01; wr_a[0] = 5'd9; wr_d[0] = 16'h0099;
        step();
        rd_v = '0; wr_v = '0;
        rst_n = 1'b0;
        #1;
        check("rst.s_rsp_valid", s_rv, 2'b00);
        check("rst.b_rsp_valid", b_rv, 2'b00);
        rd_ptr = 0; wr_ptr = 0; pend_rw = -1;
        #2 rst_n = 1'b1;
        rd_v = 2'b11; wr_v = 2'b11;
        check_cycle();
        check("rst.rd_tie", a_rr, 2'b01);
        check("rst.wr_tie", a_wr, 2'b01);
        advance();

        // Randomized traffic obeying hold-until-ready
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!rd_v[i] || last_rw == i) begin
                    rd_v[i] = ($urandom_range(0, 2) != 0);
                    rd_a[i] = AW'($urandom_range(0, 7));
                end
            end
            for (int i = 0; i < NW; i++) begin
                if (!wr_v[i] || last_ww == i) begin
                    wr_v[i] = ($urandom_range(0, 2) != 0);
                    wr_a[i] = AW'($urandom_range(0, 7));
                    wr_d[i] = DW'($urandom);
                end
            end
            step();
        end
        rd_v = '0; wr_v = '0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
